// File: rtl/fetch_unit.sv
// Instruction fetch stage: keeps the PC, issues one outstanding imem read per
// instruction and holds each returned word for the decoder until it is accepted.
// Redirects reload the PC and cause any in-flight response to be dropped.
// Optional feature macro: FETCH_EBREAK_HALT_EN (halt fetch on an accepted EBREAK).
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        halted
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
`ifdef FETCH_EBREAK_HALT_EN
    // Same encoding as opcodes::EBREAK
    localparam logic [XLEN-1:0] EBREAK = XLEN'(32'h0010_0073);
`endif

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
`ifdef FETCH_EBREAK_HALT_EN
        , HALT
`endif
    } state_t;

    state_t          state;
    logic [XLEN-1:0] pc;
    logic            discard;
    logic [XLEN-1:0] fetch_pc_c;

    // Address of the next request issued from this cycle: a redirect wins over pc
    assign fetch_pc_c = redirect ? redirect_pc : pc;

`ifndef FETCH_EBREAK_HALT_EN
    assign halted = 1'b0;
`endif

    // Fetch FSM with registered memory-side and decoder-side outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            discard     <= 1'b0;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
`ifdef FETCH_EBREAK_HALT_EN
            halted      <= 1'b0;
`endif
        end else begin
            if (redirect) begin
                pc <= redirect_pc;
            end
            case (state)
                IDLE: begin
                    state     <= REQ;
                    imem_req  <= 1'b1;
                    imem_addr <= fetch_pc_c;
                end
                REQ: begin
                    if (imem_gnt) begin
                        // A redirect racing the grant makes that response stale
                        state    <= WAIT;
                        imem_req <= 1'b0;
                        discard  <= redirect;
                    end else if (redirect) begin
                        imem_addr <= redirect_pc;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        if (discard || redirect) begin
                            state     <= REQ;
                            discard   <= 1'b0;
                            imem_req  <= 1'b1;
                            imem_addr <= fetch_pc_c;
                        end else begin
                            state       <= HOLD;
                            instr       <= imem_rdata;
                            instr_pc    <= pc;
                            instr_valid <= 1'b1;
                            pc          <= pc + PC_STEP;
                        end
                    end else if (redirect) begin
                        discard <= 1'b1;
                    end
                end
                HOLD: begin
                    if (redirect || !stall) begin
                        instr_valid <= 1'b0;
                        state       <= REQ;
                        imem_req    <= 1'b1;
                        imem_addr   <= fetch_pc_c;
`ifdef FETCH_EBREAK_HALT_EN
                        if (!redirect && (instr == EBREAK)) begin
                            state    <= HALT;
                            imem_req <= 1'b0;
                            halted   <= 1'b1;
                        end
`endif
                    end
                end
`ifdef FETCH_EBREAK_HALT_EN
                HALT: begin
                    if (redirect) begin
                        state     <= REQ;
                        halted    <= 1'b0;
                        imem_req  <= 1'b1;
                        imem_addr <= redirect_pc;
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
